// File: rtl/regfile_2r1w_param.sv
// Parametrised 2-read/1-write register file with registered, enable-gated reads,
// write-first bypass, a sequential clear engine and out-of-range address handling.
// Optional feature macro: REGFILE_R0_ZERO_EN (entry 0 hardwired to zero).
module regfile_2r1w_param #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [AW-1:0]    Addr_A,
  input  logic [AW-1:0]    Addr_B,
  input  logic [AW-1:0]    Addr_W,
  input  logic             WR,
  input  logic [WIDTH-1:0] Data_in,
  input  logic             RD_EN,
  input  logic             CLR,
  output logic [WIDTH-1:0] Src,
  output logic [WIDTH-1:0] Dest,
  output logic             Rd_valid,
  output logic             Busy
);

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0Zero = 1'b1;
`else
  localparam bit R0Zero = 1'b0;
`endif

  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] src_q, src_d;
  logic [WIDTH-1:0] dest_q, dest_d;
  logic             rd_valid_q, rd_valid_d;

  logic [DEPTH-1:0] wr_hit;
  logic [WIDTH-1:0] rd_a, rd_b;

  // Per-entry write match; out-of-range addresses never match, entry 0 is
  // excluded when hardwired to zero (which also suppresses its bypass).
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_hit[i] = WR && (Addr_W == AW'(i)) && !(R0Zero && (i == 0));
    end
  end

  // Read muxes with write-first bypass; out-of-range addresses read zero.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (Addr_A == AW'(i)) rd_a = wr_hit[i] ? Data_in : mem_q[i];
      if (Addr_B == AW'(i)) rd_b = wr_hit[i] ? Data_in : mem_q[i];
    end
  end

  // Next-state logic: normal access in idle, one entry zeroed per cycle in clear.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_d      = mem_q;
    src_d      = src_q;
    dest_d     = dest_q;
    rd_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_hit[i]) mem_d[i] = Data_in;
        end
        if (RD_EN) begin
          src_d      = rd_a;
          dest_d     = rd_b;
          rd_valid_d = 1'b1;
        end
        // Same-cycle WR/RD_EN are still serviced; clear takes over afterwards.
        if (CLR) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (cnt_q == AW'(i)) mem_d[i] = '0;
        end
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LastIdx) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      src_q      <= '0;
      dest_q     <= '0;
      rd_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      src_q      <= src_d;
      dest_q     <= dest_d;
      rd_valid_q <= rd_valid_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign Src      = src_q;
  assign Dest     = dest_q;
  assign Rd_valid = rd_valid_q;
  assign Busy     = (state_q == StClear);

endmodule

// File: doc/regfile_2r1w_param.md
Name: regfile_2r1w_param

Overview:
- Parametrised 2-read/1-write register file for the datapath; successor to the fixed 8x16 file.
- Adds a dedicated write address, registered reads gated by a read enable, and write-first bypass.
- Adds a multi-cycle clear engine and explicit out-of-range address handling.
- Sits between the decode stage (addresses, WR) and the ALU operand latches (Src, Dest).

Parameters:
- WIDTH, 16: data word width in bits.
- DEPTH, 8: number of registers; 2 <= DEPTH <= 2**AW.
- AW, 4: address port width; addresses >= DEPTH are out of range.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RSTn  input  1  asynchronous, active-low reset.
- Addr_A  input  AW  read port A address, drives Src.
- Addr_B  input  AW  read port B address, drives Dest.
- Addr_W  input  AW  write address.
- WR  input  1  write enable.
- Data_in  input  WIDTH  write data.
- RD_EN  input  1  read enable; updates Src and Dest.
- CLR  input  1  clear request; one-cycle pulse starts a sequential clear.
- Src  output  WIDTH  registered read data, port A.
- Dest  output  WIDTH  registered read data, port B.
- Rd_valid  output  1  high for the cycle after an accepted read.
- Busy  output  1  high while the clear engine runs.

Behaviour:
- Reset: RSTn low asynchronously forces the following, held while RSTn is low:
  - all DEPTH entries = 0;
  - Src = Dest = 0, Rd_valid = 0, Busy = 0;
  - FSM = IDLE, clear counter = 0.
- FSM states: IDLE and CLEAR.
- Write (IDLE only):
  - At a rising edge with WR=1 and Addr_W < DEPTH, entry[Addr_W] <= Data_in.
  - Addr_W >= DEPTH: write dropped, no side effects.
- Read (IDLE only):
  - At a rising edge with RD_EN=1: Src <= rd(Addr_A), Dest <= rd(Addr_B), Rd_valid <= 1.
  - Otherwise Src and Dest hold and Rd_valid <= 0.
  - Latency: one cycle from RD_EN sampled to data/Rd_valid on the outputs.
- rd(x) is defined as:
  - 0 if x >= DEPTH;
  - else Data_in if WR=1 and Addr_W == x (write-first bypass, same edge);
  - else entry[x].
- Both ports may address the same entry; both receive identical data.
- Clear FSM:
  - IDLE -> CLEAR when CLR=1 at an edge; counter <= 0, Busy <= 1.
  - A WR or RD_EN in that same cycle is still serviced; CLR wins only for subsequent cycles.
  - In CLEAR, each edge: entry[counter] <= 0, counter <= counter+1.
  - When counter == DEPTH-1, that entry clears, FSM -> IDLE, Busy <= 0.
  - Busy is high for exactly DEPTH cycles.
  - During CLEAR: WR ignored; RD_EN ignored (Src/Dest hold, Rd_valid = 0); CLR ignored.
  - Reset during CLEAR aborts to IDLE with all state zero.
- Width rules: counter is AW bits; no arithmetic on data; Data_in is stored unmodified.

Optional Feature:
- Macro: REGFILE_R0_ZERO_EN.
- Defined:
  - entry 0 is hardwired 0;
  - writes to address 0 are dropped;
  - rd(0) = 0 even when a same-cycle write targets 0 (bypass suppressed);
  - the clear engine still takes DEPTH cycles.
- Undefined: entry 0 is an ordinary register.

Test Plan:
- Reset/readback: assert RSTn=0 mid-run, release, RD_EN with Addr_A=3, Addr_B=7 -> Src=0, Dest=0, Rd_valid=1 one cycle later.
- Write/read: WR Addr_W=5 Data_in=16'hBEEF, next cycle RD_EN Addr_A=5 -> Src=16'hBEEF after one cycle; Dest for Addr_B=2 = 0.
- Bypass: same edge WR Addr_W=4 Data_in=16'h1234 and RD_EN Addr_A=Addr_B=4 -> Src=Dest=16'h1234.
- Out of range: WR Addr_W=9 Data_in=16'hFFFF, then read Addr_A=9 and Addr_A=1 -> both Src=0, no entry modified.
- Clear: fill entries 0..7 with 16'h00A0+i, pulse CLR -> Busy high exactly 8 cycles; WR and RD_EN issued during Busy are ignored with Rd_valid=0; afterwards all reads return 0; RSTn pulse at cycle 3 of clear -> Busy=0 immediately.
- R0 (macro defined): WR Addr_W=0 Data_in=16'h5555 with RD_EN Addr_A=0 same edge, then read again -> Src=0 both times.
